// File: rtl/multi_issue_scheduler.sv
// In-order multi-issue scheduler with an integrated register scoreboard.
// Optional macro SCHED_RETIRE_BYPASS_EN: same-cycle retires unblock dependent issue.
module multi_issue_scheduler #(
    parameter int ISSUE_W  = 2,
    parameter int RETIRE_W = 2,
    parameter int NUM_ALU  = 2,
    parameter int FU_W     = $clog2(NUM_ALU + 1),
    parameter int CNT_W    = $clog2(ISSUE_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ISSUE_W*64-1:0]     fifo_data_i,
    input  logic [ISSUE_W-1:0]        fifo_valid_i,
    output logic [CNT_W-1:0]          deq_count_o,
    input  logic [NUM_ALU-1:0]        alu_ready_i,
    input  logic                      mem_ready_i,
    input  logic [RETIRE_W-1:0]       retire_valid_i,
    input  logic [RETIRE_W*5-1:0]     retire_rd_i,
    input  logic                      flush_i,
    output logic [ISSUE_W*64-1:0]     issue_instr_o,
    output logic [ISSUE_W-1:0]        issue_valid_o,
    output logic [ISSUE_W*FU_W-1:0]   issue_fu_o,
    output logic [31:0]               sb_busy_o,
    output logic [15:0]               stall_count_o
);

    logic [31:0]             r_busy;
    logic [ISSUE_W-1:0]      r_valid;
    logic [ISSUE_W*64-1:0]   r_instr;
    logic [ISSUE_W*FU_W-1:0] r_fu;
    logic [15:0]             r_stall;

    logic [31:0]             w_retire_mask;
    logic [31:0]             w_busy_view;
    logic [31:0]             w_set_mask;
    logic [ISSUE_W-1:0]      w_issue;
    logic [ISSUE_W*FU_W-1:0] w_fu;
    logic [CNT_W-1:0]        w_cnt;
    logic                    w_stall;

    function automatic logic f_is_mem(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    function automatic logic f_writes(input logic [31:0] ins);
        logic w_hit;
        case (ins[6:0])
            7'b0110011, 7'b0000011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: w_hit = 1'b1;
            default:                            w_hit = 1'b0;
        endcase
        return w_hit && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic f_uses_rs1(input logic [6:0] op);
        return !((op == 7'b0110111) || (op == 7'b0010111) ||
                 (op == 7'b1101111));
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0100011) ||
               (op == 7'b1100011);
    endfunction

    always_comb begin
        w_retire_mask = '0;
        for (int p = 0; p < RETIRE_W; p++) begin
            if (retire_valid_i[p]) begin
                w_retire_mask[retire_rd_i[p*5 +: 5]] = 1'b1;
            end
        end
    end

`ifdef SCHED_RETIRE_BYPASS_EN
    assign w_busy_view = r_busy & ~w_retire_mask;
`else
    assign w_busy_view = r_busy;
`endif

    // Walk the head window oldest first; the first refused lane ends the bundle.
    always_comb begin
        logic                w_blocked;
        logic                w_ok;
        logic                w_mem;
        logic                w_wr;
        logic                w_mem_free;
        logic [NUM_ALU-1:0]  w_alu_free;
        logic [NUM_ALU-1:0]  w_grant;
        logic [31:0]         w_ins;
        logic [4:0]          w_rd;
        logic [4:0]          w_rs1;
        logic [4:0]          w_rs2;
        logic [FU_W-1:0]     w_unit;
        w_blocked  = rst | flush_i;
        w_mem_free = mem_ready_i;
        w_alu_free = alu_ready_i;
        w_set_mask = '0;
        w_issue    = '0;
        w_fu       = '0;
        w_cnt      = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_ins  = fifo_data_i[k*64 +: 32];
            w_rd   = w_ins[11:7];
            w_rs1  = w_ins[19:15];
            w_rs2  = w_ins[24:20];
            w_mem  = f_is_mem(w_ins[6:0]);
            w_wr   = f_writes(w_ins);
            w_ok   = fifo_valid_i[k] & ~w_blocked;
            w_unit = '0;
            w_grant = w_alu_free & (~w_alu_free + NUM_ALU'(1));
            if (f_uses_rs1(w_ins[6:0]) && (w_rs1 != 5'd0) &&
                (w_busy_view[w_rs1] || w_set_mask[w_rs1])) begin
                w_ok = 1'b0;
            end
            if (f_uses_rs2(w_ins[6:0]) && (w_rs2 != 5'd0) &&
                (w_busy_view[w_rs2] || w_set_mask[w_rs2])) begin
                w_ok = 1'b0;
            end
            if (w_wr && (w_busy_view[w_rd] || w_set_mask[w_rd])) begin
                w_ok = 1'b0;
            end
            if (w_mem) begin
                w_unit = FU_W'(NUM_ALU);
                if (!w_mem_free) begin
                    w_ok = 1'b0;
                end
            end else begin
                for (int u = 0; u < NUM_ALU; u++) begin
                    if (w_grant[u]) begin
                        w_unit = FU_W'(u);
                    end
                end
                if (w_grant == '0) begin
                    w_ok = 1'b0;
                end
            end
            if (w_ok) begin
                w_issue[k]              = 1'b1;
                w_fu[k*FU_W +: FU_W]    = w_unit;
                w_cnt                   = w_cnt + CNT_W'(1);
                if (w_mem) begin
                    w_mem_free = 1'b0;
                end else begin
                    w_alu_free = w_alu_free & ~w_grant;
                end
                if (w_wr) begin
                    w_set_mask[w_rd] = 1'b1;
                end
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

    assign w_stall = fifo_valid_i[0] & (w_cnt == '0) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_valid <= '0;
            r_instr <= '0;
            r_fu    <= '0;
            r_stall <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= '0;
                r_busy  <= '0;
            end else begin
                r_valid <= w_issue;
                for (int k = 0; k < ISSUE_W; k++) begin
                    if (w_issue[k]) begin
                        r_instr[k*64 +: 64]  <= fifo_data_i[k*64 +: 64];
                        r_fu[k*FU_W +: FU_W] <= w_fu[k*FU_W +: FU_W];
                    end
                end
                // A register both retiring and re-issued stays busy.
                r_busy <= ((r_busy & ~w_retire_mask) | w_set_mask) &
                          ~32'h1;
            end
            if (w_stall && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign deq_count_o   = w_cnt;
    assign issue_instr_o = r_instr;
    assign issue_valid_o = r_valid;
    assign issue_fu_o    = r_fu;
    assign sb_busy_o     = r_busy;
    assign stall_count_o = r_stall;

endmodule

// File: tb/tb_multi_issue_scheduler.sv
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_multi_issue_scheduler;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] fifo_data_i;
    logic [1:0]   fifo_valid_i;
    logic [1:0]   deq_count_o;
    logic [1:0]   alu_ready_i;
    logic         mem_ready_i;
    logic [1:0]   retire_valid_i;
    logic [9:0]   retire_rd_i;
    logic         flush_i;
    logic [127:0] issue_instr_o;
    logic [1:0]   issue_valid_o;
    logic [3:0]   issue_fu_o;
    logic [31:0]  sb_busy_o;
    logic [15:0]  stall_count_o;

    int total = 0;
    int bad   = 0;

    logic [31:0]  m_busy;
    logic [15:0]  m_stall;
    logic [1:0]   m_valid;
    logic [127:0] m_instr;
    logic [3:0]   m_fu;

    multi_issue_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_data_i    (fifo_data_i),
        .fifo_valid_i   (fifo_valid_i),
        .deq_count_o    (deq_count_o),
        .alu_ready_i    (alu_ready_i),
        .mem_ready_i    (mem_ready_i),
        .retire_valid_i (retire_valid_i),
        .retire_rd_i    (retire_rd_i),
        .flush_i        (flush_i),
        .issue_instr_o  (issue_instr_o),
        .issue_valid_o  (issue_valid_o),
        .issue_fu_o     (issue_fu_o),
        .sb_busy_o      (sb_busy_o),
        .stall_count_o  (stall_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    function automatic bit is_mem(input logic [6:0] op);
        return op == OP_LD || op == OP_ST;
    endfunction

    function automatic bit writes(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (ins[11:7] == 5'd0) return 0;
        return op == OP_R || op == OP_LD || op == OP_I || op == OP_LUI ||
               op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111;
    endfunction

    function automatic bit use1(input logic [6:0] op);
        return !(op == OP_LUI || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit use2(input logic [6:0] op);
        return op == OP_R || op == OP_ST || op == OP_BR;
    endfunction

    function automatic int nth_set(input logic [1:0] ar, input int n);
        int c;
        c = 0;
        for (int i = 0; i < 2; i++) begin
            if (ar[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    // Longest ready prefix, units handed out oldest first.
    function automatic void model_eval(input logic [127:0] d,
        input logic [1:0] fv, input logic [1:0] ar, input logic mr,
        input logic fl, input logic [31:0] view,
        output int m, output logic [3:0] fu, output logic [31:0] setm);
        int nalu;
        bit memtaken;
        bit ok;
        int idx;
        logic [31:0] ins;
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        m = 0; fu = '0; setm = '0; nalu = 0; memtaken = 0;
        if (fl) return;
        for (int k = 0; k < 2; k++) begin
            if (!fv[k]) break;
            ins = d[k*64 +: 32];
            op = ins[6:0]; rd = ins[11:7];
            rs1 = ins[19:15]; rs2 = ins[24:20];
            ok = 1; idx = 0;
            if (use1(op) && rs1 != 0 && (view[rs1] || setm[rs1])) ok = 0;
            if (use2(op) && rs2 != 0 && (view[rs2] || setm[rs2])) ok = 0;
            if (writes(ins) && (view[rd] || setm[rd])) ok = 0;
            if (is_mem(op)) begin
                if (memtaken || !mr) ok = 0;
            end else begin
                idx = nth_set(ar, nalu);
                if (idx < 0) ok = 0;
            end
            if (!ok) break;
            if (is_mem(op)) begin
                memtaken = 1;
                fu[k*2 +: 2] = 2'd2;
            end else begin
                fu[k*2 +: 2] = 2'(idx);
                nalu++;
            end
            if (writes(ins)) setm[rd] = 1'b1;
            m++;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 8))
            0: op = OP_R;
            1: op = OP_LD;
            2: op = OP_ST;
            3: op = OP_I;
            4: op = OP_LUI;
            5: op = 7'b0010111;
            6: op = 7'b1101111;
            7: op = 7'b1100111;
            default: op = OP_BR;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), op};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        fifo_data_i = '0; fifo_valid_i = '0;
        alu_ready_i = '0; mem_ready_i = 1'b0;
        retire_valid_i = '0; retire_rd_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_busy = '0; m_stall = '0; m_valid = '0; m_instr = '0; m_fu = '0;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1,
        input logic [1:0] fv, input logic [1:0] ar, input logic mr);
        @(negedge clk);
        fifo_data_i  = {32'h0000_1004, i1, 32'h0000_1000, i0};
        fifo_valid_i = fv;
        alu_ready_i  = ar;
        mem_ready_i  = mr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(enc(OP_R, 3, 1, 2), enc(OP_I, 5, 4, 1), 2'b11, 2'b11, 1'b1);
        #1;
        total++;
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL reset_deq: got %0d want 0", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if ({issue_valid_o, issue_fu_o, sb_busy_o, stall_count_o} !== '0 ||
            issue_instr_o !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b fu=%h busy=%h stall=%h",
                     issue_valid_o, issue_fu_o, sb_busy_o, stall_count_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_independent_pair();
        logic [31:0] i0, i1;
        do_reset();
        i0 = enc(OP_R, 3, 1, 2);
        i1 = enc(OP_I, 5, 4, 1);
        drive(i0, i1, 2'b11, 2'b11, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd2) begin
            bad++; $display("FAIL pair_deq: got %0d want 2", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (issue_valid_o !== 2'b11) begin
            bad++; $display("FAIL pair_valid: got %b want 11", issue_valid_o);
        end
        total++;
        if (issue_fu_o !== 4'b0100) begin
            bad++; $display("FAIL pair_fu: got %b want 0100", issue_fu_o);
        end
        total++;
        if (sb_busy_o !== 32'h28) begin
            bad++; $display("FAIL pair_busy: got %h want 28", sb_busy_o);
        end
        total++;
        if (issue_instr_o !== {32'h1004, i1, 32'h1000, i0}) begin
            bad++; $display("FAIL pair_instr: got %h", issue_instr_o);
        end
    endtask

    task automatic test_raw();
        logic [31:0] i0, i1;
        do_reset();
        i0 = enc(OP_I, 3, 0, 1);
        i1 = enc(OP_R, 4, 3, 3);
        drive(i0, i1, 2'b11, 2'b11, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL raw_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (issue_valid_o !== 2'b01 || sb_busy_o !== 32'h8) begin
            bad++;
            $display("FAIL raw_first: valid=%b busy=%h want 01/8",
                     issue_valid_o, sb_busy_o);
        end
        drive(i1, 32'h0, 2'b01, 2'b11, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL raw_stall: got %0d want 0", deq_count_o);
        end
        drive(i1, 32'h0, 2'b01, 2'b11, 1'b0);
        retire_valid_i = 2'b01;
        retire_rd_i    = {5'd0, 5'd3};
        #1;
        total++;
`ifdef SCHED_RETIRE_BYPASS_EN
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL raw_retire_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
`else
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL raw_retire_deq: got %0d want 0", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (sb_busy_o !== 32'h0) begin
            bad++; $display("FAIL raw_cleared: got %h want 0", sb_busy_o);
        end
        drive(i1, 32'h0, 2'b01, 2'b11, 1'b0);
        retire_valid_i = '0;
        #1;
        total++;
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL raw_after_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
`endif
        total++;
        if (sb_busy_o !== 32'h10 || issue_valid_o !== 2'b01) begin
            bad++;
            $display("FAIL raw_dep_issue: busy=%h valid=%b want 10/01",
                     sb_busy_o, issue_valid_o);
        end
        retire_valid_i = '0;
    endtask

    task automatic test_waw_resources();
        logic [31:0] lui7;
        do_reset();
        lui7 = {20'd1, 5'd7, OP_LUI};
        drive(lui7, 32'h0, 2'b01, 2'b11, 1'b0);
        drive(lui7, 32'h0, 2'b01, 2'b11, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL waw_deq: got %0d want 0", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (stall_count_o !== 16'd1 || issue_valid_o !== 2'b00) begin
            bad++;
            $display("FAIL waw_stall: stall=%0d valid=%b want 1/00",
                     stall_count_o, issue_valid_o);
        end
        drive(enc(OP_LD, 1, 2, 0), enc(OP_LD, 6, 2, 4), 2'b11, 2'b11, 1'b1);
        #1;
        total++;
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL two_loads_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (issue_fu_o[1:0] !== 2'd2 || issue_valid_o !== 2'b01) begin
            bad++;
            $display("FAIL load_fu: fu=%0d valid=%b want 2/01",
                     issue_fu_o[1:0], issue_valid_o);
        end
        drive(enc(OP_I, 9, 0, 5), 32'h0, 2'b01, 2'b10, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL alu1_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (issue_fu_o[1:0] !== 2'd1) begin
            bad++; $display("FAIL alu1_fu: got %0d want 1", issue_fu_o[1:0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(enc(OP_I, 4, 0, 1), enc(OP_I, 5, 0, 1), 2'b11, 2'b11, 1'b0);
        drive(enc(OP_I, 6, 0, 1), enc(OP_I, 7, 0, 1), 2'b11, 2'b11, 1'b0);
        @(posedge clk); #1;
        total++;
        if (sb_busy_o !== 32'hF0) begin
            bad++; $display("FAIL flush_setup: got %h want f0", sb_busy_o);
        end
        drive(enc(OP_I, 9, 0, 1), enc(OP_I, 10, 0, 1), 2'b11, 2'b11, 1'b0);
        flush_i = 1'b1;
        retire_valid_i = 2'b01;
        retire_rd_i = {5'd0, 5'd4};
        #1;
        total++;
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL flush_deq: got %0d want 0", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (sb_busy_o !== 32'h0 || issue_valid_o !== 2'b00) begin
            bad++;
            $display("FAIL flush_state: busy=%h valid=%b want 0/00",
                     sb_busy_o, issue_valid_o);
        end
        total++;
        if (stall_count_o !== 16'd0) begin
            bad++; $display("FAIL flush_nostall: got %0d want 0", stall_count_o);
        end
        flush_i = 1'b0;
        retire_valid_i = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut.r_stall = 16'hFFFE;
        #1;
        release dut.r_stall;
        drive(enc(OP_I, 1, 0, 1), 32'h0, 2'b01, 2'b00, 1'b0);
        @(posedge clk); #1;
        total++;
        if (stall_count_o !== 16'hFFFF) begin
            bad++; $display("FAIL sat_first: got %h want ffff", stall_count_o);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (stall_count_o !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold: got %h want ffff", stall_count_o);
        end
        drive(enc(OP_I, 1, 0, 1), enc(OP_I, 2, 0, 1), 2'b11, 2'b11, 1'b0);
        drive(enc(OP_I, 3, 0, 1), enc(OP_I, 4, 0, 1), 2'b11, 2'b11, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (deq_count_o !== 2'd0) begin
            bad++; $display("FAIL midrst_deq: got %0d want 0", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if ({issue_valid_o, issue_fu_o, sb_busy_o, stall_count_o} !== '0 ||
            issue_instr_o !== '0) begin
            bad++;
            $display("FAIL midrst_state: valid=%b fu=%h busy=%h stall=%h",
                     issue_valid_o, issue_fu_o, sb_busy_o, stall_count_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_x0_branch();
        do_reset();
        drive(enc(OP_BR, 0, 0, 0), 32'h0, 2'b01, 2'b01, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd1) begin
            bad++; $display("FAIL beq_deq: got %0d want 1", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (issue_fu_o[1:0] !== 2'd0 || sb_busy_o !== 32'h0) begin
            bad++;
            $display("FAIL beq_issue: fu=%0d busy=%h want 0/0",
                     issue_fu_o[1:0], sb_busy_o);
        end
        drive(enc(OP_R, 0, 1, 1), enc(OP_I, 0, 2, 3), 2'b11, 2'b11, 1'b0);
        #1;
        total++;
        if (deq_count_o !== 2'd2) begin
            bad++; $display("FAIL x0_deq: got %0d want 2", deq_count_o);
        end
        @(posedge clk); #1;
        total++;
        if (sb_busy_o !== 32'h0 || issue_fu_o !== 4'b0100) begin
            bad++;
            $display("FAIL x0_busy: busy=%h fu=%b want 0/0100",
                     sb_busy_o, issue_fu_o);
        end
    endtask

    task automatic test_random();
        int m;
        logic [3:0] fu;
        logic [31:0] setm, view, retm;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                fifo_data_i[k*64 +: 64] = {$urandom(), rand_instr()};
            end
            fifo_valid_i = 2'($urandom_range(0, 3));
            alu_ready_i  = 2'($urandom_range(0, 3));
            mem_ready_i  = 1'($urandom_range(0, 1));
            flush_i      = ($urandom_range(0, 24) == 0);
            retm = '0;
            for (int p = 0; p < 2; p++) begin
                retire_valid_i[p] = ($urandom_range(0, 2) != 0);
                retire_rd_i[p*5 +: 5] = 5'($urandom_range(0, 7));
                if (retire_valid_i[p]) retm[retire_rd_i[p*5 +: 5]] = 1'b1;
            end
`ifdef SCHED_RETIRE_BYPASS_EN
            view = m_busy & ~retm;
`else
            view = m_busy;
`endif
            model_eval(fifo_data_i, fifo_valid_i, alu_ready_i, mem_ready_i,
                       flush_i, view, m, fu, setm);
            #1;
            total++;
            if (deq_count_o !== 2'(m)) begin
                bad++;
                $display("FAIL rnd_deq c=%0d: got %0d want %0d",
                         c, deq_count_o, m);
            end
            @(posedge clk); #1;
            if (flush_i) begin
                m_valid = '0;
                m_busy  = '0;
            end else begin
                m_valid = (m == 0) ? 2'b00 : (m == 1) ? 2'b01 : 2'b11;
                for (int k = 0; k < m; k++) begin
                    m_instr[k*64 +: 64] = fifo_data_i[k*64 +: 64];
                    m_fu[k*2 +: 2] = fu[k*2 +: 2];
                end
                m_busy = ((m_busy & ~retm) | setm) & ~32'h1;
            end
            if (fifo_valid_i[0] && m == 0 && !flush_i && m_stall != 16'hFFFF)
                m_stall++;
            total++;
            if (issue_valid_o !== m_valid || issue_fu_o !== m_fu ||
                issue_instr_o !== m_instr) begin
                bad++;
                $display("FAIL rnd_bundle c=%0d: valid=%b/%b fu=%b/%b",
                         c, issue_valid_o, m_valid, issue_fu_o, m_fu);
            end
            total++;
            if (sb_busy_o !== m_busy || stall_count_o !== m_stall) begin
                bad++;
                $display("FAIL rnd_sb c=%0d: busy=%h want %h stall=%0d want %0d",
                         c, sb_busy_o, m_busy, stall_count_o, m_stall);
            end
        end
        flush_i = 1'b0;
        retire_valid_i = '0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_independent_pair();
        test_raw();
        test_waw_resources();
        test_flush();
        test_saturation();
        test_x0_branch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
